// File: rtl/mux3_arbiter.sv
// Round-robin arbiter and sequencer that owns the select of the shared 3-input datapath mux.
// Optional grant timeout (parameters CNT_W/TIMEOUT_CYCLES, timeout pulse) is compiled in with ARB_TIMEOUT_EN.
module mux3_arbiter
`ifdef ARB_TIMEOUT_EN
#(
    parameter int               CNT_W          = 8,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 8'd200
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    localparam logic [1:0] SEL_IDLE = 2'b11;

    state_e     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic [1:0] last_q, last_d;   // last granted requester; also the owner while in GRANT
    logic [1:0] win_idx;
    logic       owner_req;
    logic       force_rel;

    // Search order is last+1, last+2, last+3 (mod 3); only meaningful when |req.
    always_comb begin
        win_idx = 2'd0;
        case (last_q)
            2'd0: begin
                if (req[1])      win_idx = 2'd1;
                else if (req[2]) win_idx = 2'd2;
                else             win_idx = 2'd0;
            end
            2'd1: begin
                if (req[2])      win_idx = 2'd2;
                else if (req[0]) win_idx = 2'd0;
                else             win_idx = 2'd1;
            end
            default: begin
                if (req[0])      win_idx = 2'd0;
                else if (req[1]) win_idx = 2'd1;
                else             win_idx = 2'd2;
            end
        endcase
    end

    always_comb begin
        case (last_q)
            2'd0:    owner_req = req[0];
            2'd1:    owner_req = req[1];
            default: owner_req = req[2];
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT_CYCLES - 1'b1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign force_rel = (state_q == ST_GRANT) && (cnt_q == TO_LAST);

    // Counter sits at zero outside GRANT, so it reads 0 in the first granted cycle.
    always_comb begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (state_q == ST_GRANT) begin
            cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            timeout_d = force_rel && !done && owner_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    gnt_d   = 3'b001 << win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                    last_d  = win_idx;
                end
            end
            ST_GRANT: begin
                // done, owner drop and timeout may coincide; any of them gives one release.
                if (done || !owner_req || force_rel) begin
                    state_d = ST_TURN;
                    gnt_d   = 3'b000;
                    sel_d   = SEL_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
                sel_d   = SEL_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 3'b000;
            sel_q   <= SEL_IDLE;
            busy_q  <= 1'b0;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux3_arbiter.sv
// Self-checking bench for mux3_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model.
module tb_mux3_arbiter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req   = 3'b000;
    logic       done  = 1'b0;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int TO_CYCLES = 4;
    localparam logic [6:0] IDLE_OUT = {3'b000, 2'b11, 1'b0, 1'b0};

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    mux3_arbiter #(.CNT_W(8), .TIMEOUT_CYCLES(8'd4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
    );
`else
    localparam bit TO_EN = 1'b0;
    mux3_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
    );
`endif

    always #5 clk = ~clk;

    // Reference model: mode 0 = nobody owns the path, 1 = owned, 2 = turnaround gap.
    int m_mode, m_owner, m_last, m_held;
    bit m_to;

    task automatic model_reset();
        m_mode  = 0;
        m_owner = 0;
        m_last  = 2;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] r, input logic d);
        bit found;
        bit hit;
        m_to = 1'b0;
        case (m_mode)
            0: begin
                found = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    if (!found && r[(m_last + k) % 3]) begin
                        found   = 1'b1;
                        m_owner = (m_last + k) % 3;
                    end
                end
                if (found) begin
                    m_last = m_owner;
                    m_held = 1;
                    m_mode = 1;
                end
            end
            1: begin
                hit = TO_EN && (m_held >= TO_CYCLES);
                if (d || !r[m_owner] || hit) begin
                    m_to   = hit && !d && r[m_owner];
                    m_mode = 2;
                end else begin
                    m_held++;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    function automatic logic [6:0] model_out();
        logic [2:0] g;
        logic [1:0] s;
        g = (m_mode == 1) ? 3'(1 << m_owner) : 3'b000;
        s = (m_mode == 1) ? 2'(m_owner) : 2'b11;
        return {g, s, (m_mode == 1), m_to};
    endfunction

    function automatic logic [6:0] obs();
        return {gnt, sel, busy, timeout};
    endfunction

    // Drive inputs just after an edge, clock once, advance the model, sample 1ns later.
    task automatic tick(input logic [2:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 3'b000;
        done  = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_checks++;
        if (obs() !== IDLE_OUT) $display("FAIL reset_outputs: got %b expected %b", obs(), IDLE_OUT);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(3'b000, 1'b0);
        n_checks++;
        if (obs() !== IDLE_OUT) $display("FAIL reset_idle_hold: got %b expected %b", obs(), IDLE_OUT);
        else n_pass++;
    endtask

    task automatic test_single_grant();
        tick(3'b010, 1'b0);
        n_checks++;
        if (obs() !== 7'b010_01_1_0) $display("FAIL single_grant: got %b expected %b", obs(), 7'b010_01_1_0);
        else n_pass++;
        tick(3'b010, 1'b0);
        tick(3'b010, 1'b0);
        n_checks++;
        if (obs() !== 7'b010_01_1_0) $display("FAIL single_hold: got %b expected %b", obs(), 7'b010_01_1_0);
        else n_pass++;
        tick(3'b000, 1'b1);
        n_checks++;
        if (obs() !== IDLE_OUT) $display("FAIL single_release: got %b expected %b", obs(), IDLE_OUT);
        else n_pass++;
        tick(3'b000, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [4];
        logic [1:0] exp_s [4];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_s = '{2'b00, 2'b01, 2'b10, 2'b00};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(3'b111, 1'b0);
            n_checks++;
            if ({gnt, sel, busy} !== {exp_g[i], exp_s[i], 1'b1})
                $display("FAIL rr_grant_%0d: got gnt=%b sel=%b busy=%b expected gnt=%b sel=%b busy=1",
                         i, gnt, sel, busy, exp_g[i], exp_s[i]);
            else n_pass++;
            tick(3'b111, 1'b1);
            n_checks++;
            if (obs() !== IDLE_OUT) $display("FAIL rr_gap_a_%0d: got %b expected %b", i, obs(), IDLE_OUT);
            else n_pass++;
            tick(3'b111, 1'b0);
            n_checks++;
            if (obs() !== IDLE_OUT) $display("FAIL rr_gap_b_%0d: got %b expected %b", i, obs(), IDLE_OUT);
            else n_pass++;
        end
        req = 3'b000;
        tick(3'b000, 1'b0);
        tick(3'b000, 1'b0);
    endtask

    task automatic test_req_drop();
        tick(3'b001, 1'b0);
        n_checks++;
        if (obs() !== 7'b001_00_1_0) $display("FAIL drop_grant0: got %b expected %b", obs(), 7'b001_00_1_0);
        else n_pass++;
        tick(3'b100, 1'b0);
        n_checks++;
        if (obs() !== IDLE_OUT) $display("FAIL drop_release: got %b expected %b", obs(), IDLE_OUT);
        else n_pass++;
        tick(3'b100, 1'b0);
        n_checks++;
        if (obs() !== IDLE_OUT) $display("FAIL drop_turn: got %b expected %b", obs(), IDLE_OUT);
        else n_pass++;
        tick(3'b100, 1'b0);
        n_checks++;
        if (obs() !== 7'b100_10_1_0) $display("FAIL drop_grant2: got %b expected %b", obs(), 7'b100_10_1_0);
        else n_pass++;
    endtask

    // Entered with requester 2 holding the grant.
    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs() !== IDLE_OUT) $display("FAIL async_reset_drop: got %b expected %b", obs(), IDLE_OUT);
        else n_pass++;
        req = 3'b111;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs() !== IDLE_OUT) $display("FAIL async_reset_hold: got %b expected %b", obs(), IDLE_OUT);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(3'b111, 1'b0);
        n_checks++;
        if (obs() !== 7'b001_00_1_0) $display("FAIL async_reset_regrant: got %b expected %b", obs(), 7'b001_00_1_0);
        else n_pass++;
        tick(3'b000, 1'b0);
        tick(3'b000, 1'b0);
    endtask

    task automatic test_done_idle_and_coincident();
        for (int i = 0; i < 3; i++) begin
            tick(3'b000, 1'b1);
            n_checks++;
            if (obs() !== IDLE_OUT) $display("FAIL done_idle_%0d: got %b expected %b", i, obs(), IDLE_OUT);
            else n_pass++;
        end
        tick(3'b010, 1'b0);
        n_checks++;
        if (obs() !== 7'b010_01_1_0) $display("FAIL coinc_grant: got %b expected %b", obs(), 7'b010_01_1_0);
        else n_pass++;
        tick(3'b000, 1'b1);
        n_checks++;
        if (obs() !== IDLE_OUT) $display("FAIL coinc_release: got %b expected %b", obs(), IDLE_OUT);
        else n_pass++;
        tick(3'b000, 1'b0);
        n_checks++;
        if (obs() !== IDLE_OUT) $display("FAIL coinc_turn: got %b expected %b", obs(), IDLE_OUT);
        else n_pass++;
        tick(3'b010, 1'b0);
        n_checks++;
        if (obs() !== 7'b010_01_1_0) $display("FAIL coinc_regrant: got %b expected %b", obs(), 7'b010_01_1_0);
        else n_pass++;
        tick(3'b000, 1'b1);
        tick(3'b000, 1'b0);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cycles;
        do_reset();
        tick(3'b001, 1'b0);
        cycles = busy ? 1 : 0;
        for (int i = 0; i < 20 && busy; i++) begin
            tick(3'b001, 1'b0);
            if (busy) cycles++;
        end
        n_checks++;
        if (cycles !== TO_CYCLES) $display("FAIL timeout_busy_len: got %0d expected %0d", cycles, TO_CYCLES);
        else n_pass++;
        n_checks++;
        if (obs() !== 7'b000_11_0_1) $display("FAIL timeout_pulse: got %b expected %b", obs(), 7'b000_11_0_1);
        else n_pass++;
        tick(3'b001, 1'b0);
        n_checks++;
        if (obs() !== IDLE_OUT) $display("FAIL timeout_pulse_end: got %b expected %b", obs(), IDLE_OUT);
        else n_pass++;
        tick(3'b001, 1'b0);
        n_checks++;
        if (obs() !== 7'b001_00_1_0) $display("FAIL timeout_regrant: got %b expected %b", obs(), 7'b001_00_1_0);
        else n_pass++;
        tick(3'b000, 1'b0);
        tick(3'b000, 1'b0);
    endtask
`else
    task automatic test_long_grant();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick(3'b001, 1'b0);
            if (obs() !== 7'b001_00_1_0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL long_grant_held: got %0d bad cycles expected 0", bad);
        else n_pass++;
        tick(3'b000, 1'b0);
        tick(3'b000, 1'b0);
    endtask
`endif

    task automatic test_random();
        logic [2:0] r;
        logic       d;
        int         bad_model;
        int         bad_inv;
        r = 3'b000;
        bad_model = 0;
        bad_inv   = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 4) == 0);
            tick(r, d);
            n_checks++;
            if (obs() !== model_out()) begin
                bad_model++;
                if (bad_model <= 5)
                    $display("FAIL random_model_cycle_%0d: got %b expected %b", i, obs(), model_out());
            end else n_pass++;
            n_checks++;
            if (!$onehot0(gnt) || ((sel == 2'b11) != (gnt == 3'b000)) || ((gnt == 3'b000) != !busy)) begin
                bad_inv++;
                if (bad_inv <= 5)
                    $display("FAIL random_invariant_cycle_%0d: got gnt=%b sel=%b busy=%b expected consistent idle/grant encoding",
                             i, gnt, sel, busy);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_req_drop();
        test_async_reset();
        test_done_idle_and_coincident();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_long_grant();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux3_arbiter.md
Name: mux3_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 3-input 32-bit datapath multiplexer (mux3).
- Three requesters compete for the shared path. The block grants one requester at a time and drives the mux `sel` to route that requester's data onto `data_out`.
- It holds the grant until the transaction completes, then inserts one turnaround cycle before the next grant.
- It sits between the requesters and the mux3 select input in the SoC datapath.

Parameters:
- CNT_W, 8, width of the grant-duration counter and the timeout compare value
- TIMEOUT_CYCLES, 8'd200, maximum cycles a grant may be held; used only when ARB_TIMEOUT_EN is defined

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  3  request lines; bit i = requester i (i=0,1,2 map to mux data_in1, data_in2, data_in3)
- done  input  1  transaction-complete strobe from the target; meaningful only while busy=1
- gnt  output  3  one-hot grant, registered; 3'b000 when idle
- sel  output  2  mux select, registered: 2'b00/2'b01/2'b10 for owner 0/1/2, 2'b11 when idle
- busy  output  1  1 while any grant is held
- timeout  output  1  one-cycle pulse when a grant is force-released; tied to 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - gnt=3'b000, sel=2'b11, busy=0, timeout=0.
  - Round-robin pointer last=2, so requester 0 has first priority after reset.
  - Duration counter = 0.
- Reset asserted mid-grant: all outputs drop immediately (asynchronously) to their reset values. No completion is signalled.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req != 0, choose the first set bit searching last+1, last+2, last+3 (mod 3).
  - On the next edge: gnt=onehot(winner), sel=winner, busy=1, last=winner, counter=0, go to GRANT.
  - Latency from req seen high to gnt: 1 cycle.
  - If req == 0, remain in IDLE with outputs at idle values.
- GRANT:
  - gnt, sel and busy are held constant. The counter increments each cycle and saturates at all-ones.
  - Release condition: done=1, OR req[owner]=0, OR (ARB_TIMEOUT_EN and counter == TIMEOUT_CYCLES-1).
  - On release, next edge: gnt=000, sel=11, busy=0, go to TURN.
  - done and a req drop in the same cycle cause a single release.
  - Changes on non-owner req bits are ignored while in GRANT.
- TURN:
  - Mandatory one-cycle bus turnaround. Requests are not evaluated.
  - Go to IDLE unconditionally.
  - Minimum spacing between consecutive grants: 2 idle cycles (TURN, then IDLE evaluation).
- Fairness:
  - A continuously asserting requester is served at most once per rotation while others are pending.
  - With all three requesting continuously, the grant order is 0,1,2,0,...
- Invariants:
  - gnt is always one-hot or zero.
  - sel==2'b11 if and only if gnt==0, if and only if busy==0.
  - sel never changes while busy=1.
- done asserted in IDLE or TURN is ignored.

Optional Feature:
- ARB_TIMEOUT_EN
- Defined:
  - A grant held for TIMEOUT_CYCLES cycles is force-released through the normal GRANT->TURN path.
  - timeout pulses high for exactly one cycle, coincident with busy falling.
  - last keeps the timed-out owner, so it loses priority in the next rotation.
- Undefined:
  - No timeout logic is compiled.
  - timeout is tied to 0.
  - A grant lasts until done or owner req drop, however long that takes.

Test Plan:
- Reset then req=3'b010 from cycle 2 → gnt=3'b010, sel=2'b01, busy=1 at cycle 3; done pulse at cycle 6 → gnt=000, sel=11 at cycle 7; TURN at cycle 7; IDLE at cycle 8.
- req=3'b111 held; done pulsed one cycle into each grant → grant order 001, 010, 100, 001, with sel sequence 00, 01, 10, 00 and 3'b000/2'b11 gaps between grants.
- Owner 0 granted; req[0] dropped with no done → released on the next edge; pending req[2] is granted two cycles later with sel=2'b10.
- rst_n pulsed low while gnt=3'b100 → gnt=000, sel=11, busy=0 immediately, without waiting for clk; after release, req=3'b111 grants requester 0 first.
- done=1 while idle with req=0 → no output change; done and req[owner] drop in the same cycle → exactly one release, with no extra idle cycle beyond TURN.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8'd4, req=3'b001 held, no done → busy high for exactly 4 cycles, timeout=1 for 1 cycle at release, requester 0 regranted after TURN and IDLE.
